// File: rtl/lcd_ctrl.sv
// HD44780-style 8-bit LCD bus sequencer.
// Runs the power-up init sequence, then performs single-byte writes requested over valid/ready.
module lcd_ctrl #(
  parameter int POWERUP_CYC  = 750000,
  parameter int SETUP_CYC    = 4,
  parameter int EN_CYC       = 24,
  parameter int HOLD_CYC     = 4,
  parameter int CMD_WAIT_CYC = 2500,
  parameter int CLR_WAIT_CYC = 82000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       init_done,
  output logic       busy,
  output logic [7:0] LCD,
  output logic       lcdRS,
  output logic       lcdRW,
  output logic       lcdEn
);

  localparam int MAX_A   = (POWERUP_CYC > CLR_WAIT_CYC) ? POWERUP_CYC : CLR_WAIT_CYC;
  localparam int MAX_B   = (CMD_WAIT_CYC > EN_CYC) ? CMD_WAIT_CYC : EN_CYC;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] L_PWRUP = CNT_W'(POWERUP_CYC - 1);
  localparam logic [CNT_W-1:0] L_SETUP = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] L_EN    = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] L_HOLD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] L_CMD   = CNT_W'(CMD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] L_CLR   = CNT_W'(CLR_WAIT_CYC - 1);

  typedef enum logic [2:0] {
    S_PWRUP,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT,
    S_IDLE
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_data;
  logic             r_rs;
  logic             r_en;
  logic             r_ready;
  logic             r_init_done;
  logic             r_busy;

  logic [CNT_W-1:0] w_limit;
  logic             w_last;
  logic             w_clr_cmd;

  function automatic logic [7:0] init_rom(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: init_rom = 8'h38;
      3'd3:             init_rom = 8'h0C;
      3'd4:             init_rom = 8'h01;
      3'd5:             init_rom = 8'h06;
      default:          init_rom = 8'h00;
    endcase
  endfunction

  // Clear and home need the long post-write wait; the same bytes as data do not.
  assign w_clr_cmd = !r_rs && ((r_data == 8'h01) || (r_data == 8'h02));

  always_comb begin
    w_limit = '0;
    case (r_state)
      S_PWRUP: w_limit = L_PWRUP;
      S_SETUP: w_limit = L_SETUP;
      S_PULSE: w_limit = L_EN;
      S_HOLD:  w_limit = L_HOLD;
      S_WAIT:  w_limit = w_clr_cmd ? L_CLR : L_CMD;
      default: w_limit = '0;
    endcase
  end

  assign w_last = (r_cnt == w_limit);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_PWRUP;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_data      <= 8'h00;
      r_rs        <= 1'b0;
      r_en        <= 1'b0;
      r_ready     <= 1'b0;
      r_init_done <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_PWRUP: begin
          if (w_last) begin
            // LOAD folds into this edge: ROM[0] is on the bus as SETUP begins
            r_cnt   <= '0;
            r_data  <= init_rom(3'd0);
            r_rs    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_SETUP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_SETUP: begin
          if (w_last) begin
            r_cnt   <= '0;
            r_en    <= 1'b1;
            r_state <= S_PULSE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_PULSE: begin
          if (w_last) begin
            r_cnt   <= '0;
            r_en    <= 1'b0;
            r_state <= S_HOLD;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (w_last) begin
            r_cnt <= '0;
            if (!r_init_done && (r_idx < 3'd5)) begin
              r_idx   <= r_idx + 3'd1;
              r_data  <= init_rom(r_idx + 3'd1);
              r_rs    <= 1'b0;
              r_state <= S_SETUP;
            end else begin
              r_init_done <= 1'b1;
              r_busy      <= 1'b0;
              r_ready     <= 1'b1;
              r_state     <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (req_valid && r_ready) begin
            r_cnt   <= '0;
            r_data  <= req_data;
            r_rs    <= req_rs;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_SETUP;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= S_PWRUP;
        end
      endcase
    end
  end

  assign LCD       = r_data;
  assign lcdRS     = r_rs;
  assign lcdRW     = 1'b0;
  assign lcdEn     = r_en;
  assign req_ready = r_ready;
  assign init_done = r_init_done;
  assign busy      = r_busy;

endmodule

// File: doc/lcd_ctrl.md
Name: lcd_ctrl

Overview:
- Sequencer that owns the HD44780-style 8-bit character LCD bus (LCD, lcdRS, lcdRW, lcdEn) on behalf of the proc core.
- After reset it runs the controller power-up/initialisation sequence autonomously.
- It then accepts single-byte command/data write requests from the core over a valid/ready handshake and generates correctly timed enable pulses and post-write wait times.
- The core never drives LCD pins directly.

Parameters:
- POWERUP_CYC, 750000: clk cycles of idle wait after reset before the first init write.
- SETUP_CYC, 4: cycles RS/data are stable with lcdEn=0 before the enable pulse.
- EN_CYC, 24: cycles lcdEn is held high.
- HOLD_CYC, 4: cycles RS/data are held after lcdEn falls.
- CMD_WAIT_CYC, 2500: post-write wait for normal commands and data.
- CLR_WAIT_CYC, 82000: post-write wait for the clear (0x01) and home (0x02) commands.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  core has a byte to write.
- req_rs  in  1  0 = command, 1 = data.
- req_data  in  8  byte to write.
- req_ready  out  1  controller can accept a request this cycle.
- init_done  out  1  init sequence complete; stays high until reset.
- busy  out  1  a write (init or user) is in progress.
- LCD  out  8  LCD data bus.
- lcdRS  out  1  register select.
- lcdRW  out  1  read/write; tied low (write-only).
- lcdEn  out  1  enable strobe.

Behaviour:
- Reset (reset=0, async): state=PWRUP, counter=0, init index=0. LCD=0x00, lcdRS=0, lcdRW=0, lcdEn=0, req_ready=0, init_done=0, busy=0.
- Reset asserted mid-write aborts immediately. lcdEn drops asynchronously and the full init sequence reruns after release.
- All outputs are registered. lcdRW is 0 in every state.
- Single down/up counter. Each phase lasts exactly its parameter count of rising edges. The edge on which the count completes performs the transition. The first edge after reset release is PWRUP cycle 1.
- Init ROM, in order: 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06. All are commands (RS=0).
- States:
  - PWRUP: wait POWERUP_CYC, then go to LOAD.
  - LOAD: load ROM[index] into the data/RS registers. This state consumes 0 cycles: it is combinational into SETUP, so SETUP starts on the same edge.
  - SETUP: drive LCD/lcdRS, lcdEn=0, busy=1, for SETUP_CYC. Then go to PULSE.
  - PULSE: lcdEn=1 for EN_CYC. Then go to HOLD.
  - HOLD: lcdEn=0, bus held, for HOLD_CYC. Then go to WAIT.
  - WAIT: bus held, for CLR_WAIT_CYC if RS=0 and data is 0x01 or 0x02, else CMD_WAIT_CYC.
    - During init: if index<5, increment index and go to SETUP with the next ROM byte.
    - During init, index=5: set init_done=1 and go to IDLE.
    - User write: go to IDLE.
  - IDLE: busy=0, req_ready=1, bus holds the last value, lcdEn=0.
- Handshake: a transfer occurs on an edge with req_valid=1 and req_ready=1. That edge latches req_rs/req_data, clears req_ready, sets busy, and enters SETUP.
  - req_ready is high only in IDLE.
  - req_valid while not ready is ignored and must be held by the core. It is neither lost nor queued internally.
  - Back-to-back requests: the next accept can occur no earlier than the first edge in IDLE after the previous WAIT. Accept-to-accept minimum is SETUP+EN+HOLD+wait+1 cycles.
- Input changes on req_rs/req_data after acceptance have no effect on the bus.
- Counter width: enough bits for max(POWERUP_CYC, CLR_WAIT_CYC). No wrap occurs within a phase.
- A user clear/home (0x01 or 0x02 with RS=0) uses CLR_WAIT_CYC. The same byte with RS=1 uses CMD_WAIT_CYC.

Test Plan:
(All with POWERUP_CYC=20, SETUP_CYC=2, EN_CYC=4, HOLD_CYC=2, CMD_WAIT_CYC=10, CLR_WAIT_CYC=50.)
- Reset/init:
  - Stimulus: release reset, req_valid=0.
  - Response: six lcdEn pulses, each 4 cycles wide, with LCD = 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 and lcdRS=0. The first pulse rises at cycle 23.
  - init_done and req_ready rise after exactly 20+5*18+58 = 168 edges. lcdRW=0 throughout.
- Data write:
  - Stimulus: after init, pulse req_valid with rs=1, data=0x41.
  - Response: req_ready falls the next cycle. LCD=0x41, lcdRS=1 for 2 cycles before lcdEn rises. lcdEn is high 4 cycles. req_ready returns 18 cycles after acceptance.
- Clear command:
  - Stimulus: rs=0, data=0x01.
  - Response: req_ready returns 58 cycles after acceptance. rs=1, data=0x01 returns after 18 cycles.
- Early request:
  - Stimulus: hold req_valid (rs=1, data=0x55) from reset release.
  - Response: no user pulse before init_done. Accepted on the first IDLE edge. Exactly one 0x55 write.
- Back-to-back writes:
  - Stimulus: req_valid held continuously for 0x48, then 0x49, changing data on each acceptance.
  - Response: two writes with accept spacing of exactly 19 cycles. The bus is unaffected by data changes mid-write.
- Reset mid-pulse:
  - Stimulus: assert reset while lcdEn=1 during a user write.
  - Response: lcdEn=0, LCD=0, req_ready=0 and init_done=0 asynchronously. After release, the full init sequence repeats.
